// File: rtl/blu_pkg.sv
// Opcodes and shared stage-1 control type for bitwise_logic_unit.
// Define BLU_ROTATE_EN to enable opcode 6 (rotate-right); otherwise it is reported as unsupported.
package blu_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_NEG  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_ANDN = 3'd5;
    localparam logic [2:0] OP_ROTR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    // Width-independent part of the stage-1 payload.
    typedef struct packed {
        logic [2:0] op;
        logic       carry;
    } s1Ctrl_t;

    function automatic logic opIsErr(input logic [2:0] op);
`ifdef BLU_ROTATE_EN
        return op == OP_RSVD;
`else
        return (op == OP_RSVD) || (op == OP_ROTR);
`endif
    endfunction

endpackage

// File: rtl/blu_stage_reg.sv
// Valid/ready pipeline register; accepts whenever empty or when downstream drains this cycle.
module blu_stage_reg #(
    parameter int unsigned DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          upValid,
    output logic          upReady,
    input  logic [DW-1:0] upData,
    output logic          dnValid,
    input  logic          dnReady,
    output logic [DW-1:0] dnData
);

    assign upReady = !dnValid || dnReady;

    // Data only moves on a real transfer so a stalled output stays stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dnValid <= 1'b0;
            dnData  <= '0;
        end else if (upReady) begin
            dnValid <= upValid;
            if (upValid) begin
                dnData <= upData;
            end
        end
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Two-stage pipelined NOT/NEG/AND/OR/XOR/ANDN unit with a completed-operation counter.
// Optional rotate-right on opcode 6 when BLU_ROTATE_EN is defined.
module bitwise_logic_unit
    import blu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPLIT = WIDTH / 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    localparam int unsigned HI_W = WIDTH - SPLIT;
    localparam int unsigned S2_W = WIDTH + 1;

    typedef struct packed {
        s1Ctrl_t          ctrl;
        logic [SPLIT-1:0] lo;
        logic [HI_W-1:0]  aHi;
        logic [HI_W-1:0]  bHi;
    } s1Pay_t;

    localparam int unsigned S1_W = $bits(s1Pay_t);

    logic [SPLIT-1:0] aLo;
    logic [SPLIT-1:0] bLo;
    s1Pay_t           s1In;
    s1Pay_t           s1Q;
    logic             s1Valid;
    logic             s2Load;
    logic [HI_W-1:0]  hiRes;
    logic [S2_W-1:0]  s2In;
    logic [S2_W-1:0]  s2Q;

    assign aLo = in_a[SPLIT-1:0];
    assign bLo = in_b[SPLIT-1:0];

`ifdef BLU_ROTATE_EN
    localparam int unsigned SH_W = $clog2(WIDTH);
    logic [WIDTH-1:0] rotRes;
    assign rotRes = WIDTH'({in_a, in_a} >> in_b[SH_W-1:0]);
`endif

    // Stage 1: low result bits, NEG carry-out of the low part, raw high operands.
    always_comb begin
        s1In            = '0;
        s1In.ctrl.op    = in_op;
        s1In.ctrl.carry = (aLo == '0);
        s1In.aHi        = in_a[WIDTH-1:SPLIT];
        s1In.bHi        = in_b[WIDTH-1:SPLIT];
        case (in_op)
            OP_NOT:  s1In.lo = ~aLo;
            OP_NEG:  s1In.lo = ~aLo + SPLIT'(1);
            OP_AND:  s1In.lo = aLo & bLo;
            OP_OR:   s1In.lo = aLo | bLo;
            OP_XOR:  s1In.lo = aLo ^ bLo;
            OP_ANDN: s1In.lo = ~aLo & bLo;
`ifdef BLU_ROTATE_EN
            // Full rotate is done here; stage 2 just forwards aHi.
            OP_ROTR: {s1In.aHi, s1In.lo} = rotRes;
`endif
            default: s1In.lo = '0;
        endcase
    end

    // Stage 2: high result bits, NEG completes with the stage-1 carry.
    always_comb begin
        hiRes = '0;
        case (s1Q.ctrl.op)
            OP_NOT:  hiRes = ~s1Q.aHi;
            OP_NEG:  hiRes = ~s1Q.aHi + HI_W'(s1Q.ctrl.carry);
            OP_AND:  hiRes = s1Q.aHi & s1Q.bHi;
            OP_OR:   hiRes = s1Q.aHi | s1Q.bHi;
            OP_XOR:  hiRes = s1Q.aHi ^ s1Q.bHi;
            OP_ANDN: hiRes = ~s1Q.aHi & s1Q.bHi;
`ifdef BLU_ROTATE_EN
            OP_ROTR: hiRes = s1Q.aHi;
`endif
            default: hiRes = '0;
        endcase
        s2In = {opIsErr(s1Q.ctrl.op), hiRes, s1Q.lo};
    end

    blu_stage_reg #(.DW(S1_W)) uStage1 (
        .clock   (clock),
        .reset   (reset),
        .upValid (in_valid),
        .upReady (in_ready),
        .upData  (s1In),
        .dnValid (s1Valid),
        .dnReady (s2Load),
        .dnData  (s1Q)
    );

    blu_stage_reg #(.DW(S2_W)) uStage2 (
        .clock   (clock),
        .reset   (reset),
        .upValid (s1Valid),
        .upReady (s2Load),
        .upData  (s2In),
        .dnValid (out_valid),
        .dnReady (out_ready),
        .dnData  (s2Q)
    );

    assign {out_err, out_result} = s2Q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed, table-driven bench for bitwise_logic_unit; a second instance with a 4-bit counter covers wrap.
module tb_bitwise_logic_unit;
    import blu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         err;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_ready;

    logic         in_ready,  in_readyW;
    logic         out_valid, out_validW;
    logic [W-1:0] out_result, out_resultW;
    logic         out_err,   out_errW;
    logic [15:0]  out_count;
    logic [3:0]   out_countW;

    int total = 0;
    int bad   = 0;
    int expCnt = 0;
    vec_t expQ[$];

    always #5 clock = ~clock;

    bitwise_logic_unit dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
        .out_count(out_count)
    );

    bitwise_logic_unit #(.CNT_W(4)) dutW (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_readyW),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_validW),
        .out_ready(out_ready), .out_result(out_resultW), .out_err(out_errW),
        .out_count(out_countW)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] res, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.err = err;
        return v;
    endfunction

    // One cycle: drive inputs, score the output that completes at the coming edge, log an accept.
    task automatic step(input logic v, input vec_t t, input logic ordy, output logic acc);
        vec_t e;
        @(negedge clock);
        in_valid = v; in_op = t.op; in_a = t.a; in_b = t.b; out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got %h err %b, want no output", out_result, out_err);
            end else begin
                e = expQ.pop_front();
                chk($sformatf("result op%0d a=%h", e.op, e.a), {31'd0, out_err, out_result}, {31'd0, e.err, e.res});
                chk($sformatf("resultW op%0d a=%h", e.op, e.a), {31'd0, out_errW, out_resultW}, {31'd0, e.err, e.res});
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            expQ.push_back(t);
            expCnt++;
        end
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, mk(3'd0, '0, '0, '0, 1'b0), ordy, acc);
    endtask

    task automatic drain(output int steps);
        steps = 0;
        while (expQ.size() != 0 && steps < 20) begin
            idle(1'b1);
            steps++;
        end
        if (expQ.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending, want 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic chkCount(input string name);
        idle(1'b1);
        chk({name, "_count"},  64'(out_count),  64'(expCnt % 65536));
        chk({name, "_countW"}, 64'(out_countW), 64'(expCnt % 16));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        vec_t bp[3];
        logic acc;
        int   steps;
        int   accN;
        int   idx;

        tbl[0]  = mk(OP_NEG,  32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0);
        tbl[1]  = mk(OP_NEG,  32'h0001_0000, 32'h0,          32'hFFFF_0000, 1'b0);
        tbl[2]  = mk(OP_NEG,  32'h8000_0000, 32'h0,          32'h8000_0000, 1'b0);
        tbl[3]  = mk(OP_NEG,  32'h0000_8000, 32'h0,          32'hFFFF_8000, 1'b0);
        tbl[4]  = mk(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000, 1'b0);
        tbl[5]  = mk(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0);
        tbl[6]  = mk(OP_ANDN, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0F00_0F00, 1'b0);
        tbl[7]  = mk(OP_NOT,  32'h1234_5678, 32'h0,          32'hEDCB_A987, 1'b0);
        tbl[8]  = mk(OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00,  32'hFFF0_FFF0, 1'b0);
        tbl[9]  = mk(OP_RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 1'b1);
`ifdef BLU_ROTATE_EN
        tbl[10] = mk(OP_ROTR, 32'h0000_0001, 32'h0000_0001,  32'h8000_0000, 1'b0);
        tbl[11] = mk(OP_ROTR, 32'h0000_0001, 32'h0000_0000,  32'h0000_0001, 1'b0);
        tbl[12] = mk(OP_ROTR, 32'h1234_5678, 32'hFFFF_FFE4,  32'h8123_4567, 1'b0);
`else
        tbl[10] = mk(OP_ROTR, 32'h0000_0001, 32'h0000_0001,  32'h0000_0000, 1'b1);
        tbl[11] = mk(OP_ROTR, 32'h0000_0001, 32'h0000_0000,  32'h0000_0000, 1'b1);
        tbl[12] = mk(OP_ROTR, 32'h1234_5678, 32'hFFFF_FFE4,  32'h0000_0000, 1'b1);
`endif
        bp[0] = mk(OP_OR,  32'h0000_00FF, 32'h0000_FF00, 32'h0000_FFFF, 1'b0);
        bp[1] = mk(OP_AND, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'hAAAA_0000, 1'b0);
        bp[2] = mk(OP_NOT, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0);

        // Reset values, sampled while reset is held.
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_err",    64'(out_err),    64'd0);
        chk("rst_out_count",  64'(out_count),  64'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency: NEG 1 becomes visible after the second edge.
        step(1'b1, mk(OP_NEG, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 1'b0), 1'b1, acc);
        chk("lat_accept", 64'(acc), 64'd1);
        idle(1'b1);
        chk("lat_edge1_valid", 64'(out_valid), 64'd0);
        idle(1'b1);
        chk("lat_edge2_valid", 64'(out_valid), 64'd1);
        chkCount("lat");

        // Back-to-back table, one op per cycle.
        for (int i = 0; i < 13; i++) begin
            step(1'b1, tbl[i], 1'b1, acc);
            chk($sformatf("tbl_accept%0d", i), 64'(acc), 64'd1);
        end
        drain(steps);
        chk("tbl_no_bubbles", 64'(steps), 64'd2);
        chkCount("tbl");
        chk("tbl_idle_valid", 64'(out_valid), 64'd0);

        // Backpressure: 5 stalled cycles, 3 ops offered, only 2 fit.
        idx = 0; accN = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, bp[idx], 1'b0, acc);
            if (acc) begin accN++; idx++; end
            if (c >= 2) begin
                chk($sformatf("bp_hold%0d", c), {31'd0, out_valid, out_err, out_result},
                    {31'd0, 1'b1, bp[0].err, bp[0].res});
            end
        end
        chk("bp_accepted", 64'(accN), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 5 && idx < 3; c++) begin
            step(1'b1, bp[idx], 1'b1, acc);
            if (acc) idx++;
        end
        chk("bp_third_accepted", 64'(idx), 64'd3);
        drain(steps);
        chkCount("bp");

        // Asynchronous reset with two ops in flight.
        step(1'b1, tbl[4], 1'b1, acc);
        step(1'b1, tbl[5], 1'b1, acc);
        idle(1'b0);
        chk("inflight_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("arst_out_valid",  64'(out_valid),  64'd0);
        chk("arst_out_count",  64'(out_count),  64'd0);
        chk("arst_out_countW", 64'(out_countW), 64'd0);
        expQ.delete();
        expCnt = 0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            idle(1'b1);
            chk($sformatf("no_stale%0d", c), 64'(out_valid), 64'd0);
        end

        // Counter wrap on the 4-bit instance.
        for (int i = 0; i < 15; i++) begin
            step(1'b1, mk(OP_NOT, 32'(i), 32'h0, ~32'(i), 1'b0), 1'b1, acc);
        end
        drain(steps);
        chkCount("pre_wrap");
        chk("pre_wrap_w15", 64'(out_countW), 64'd15);
        step(1'b1, mk(OP_XOR, 32'h5555_5555, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b0), 1'b1, acc);
        drain(steps);
        chkCount("wrap");
        chk("wrap_w0",   64'(out_countW), 64'd0);
        chk("wrap_n16",  64'(out_count),  64'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
- Parametrised, pipelined successor to the combinational 32-bit inverter used in the miner datapath.
- Performs NOT, two's-complement NEG, AND, OR, XOR and ANDN (~a & b, the SHA-256 Ch term) on WIDTH-bit operands.
- Two-stage valid/ready pipeline; NEG carry is split across the stages to shorten the critical path.
- Sits between the SHA-256 round scheduler and the message-expansion logic; also counts completed operations.

Parameters:
- WIDTH, 32, operand/result width in bits; even, ≥ 4.
- SPLIT, WIDTH/2, number of low bits whose NEG carry is resolved in stage 1; 1 ≤ SPLIT < WIDTH.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  unit accepts when in_valid && in_ready.
- in_op  in  3  opcode: 0 NOT, 1 NEG, 2 AND, 3 OR, 4 XOR, 5 ANDN, 6 ROTR, 7 reserved.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; for ROTR, in_b[$clog2(WIDTH)-1:0] is the rotate amount.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_result  out  WIDTH  result.
- out_err  out  1  opcode unsupported; result forced to 0.
- out_count  out  CNT_W  completed output handshakes, wrapping.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - stage valids
  - out_valid = 0, out_result = 0, out_err = 0, out_count = 0
  - in_ready = 1 while reset is deasserted and stage 1 is empty.
- Reset mid-operation discards all in-flight data; no partial output appears after reset.
- Stage 1, on accept:
  - latches the op.
  - latches the low SPLIT result bits, computed as follows:
    - NEG: ~a + 1 over the low bits.
    - Other ops: the bitwise result.
  - latches the NEG carry-out of the low part: 1 iff a[SPLIT-1:0] == 0.
  - latches the raw high operand bits.
- Stage 2:
  - Computes the high bits. NEG: ~a_hi + carry. Other ops: bitwise.
  - Registers out_result and out_err.
- Latency: result is valid 2 cycles after the accept edge when out_ready is held high.
- Throughput: 1 op per cycle.
- Handshake:
  - Stage 2 loads when it is empty or out_ready is high.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid || s2_load. in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
  - A held out_valid keeps out_result and out_err stable until the output handshake.
  - Simultaneous accept and output handshake is legal; there are no bubbles at full rate.
- Arithmetic:
  - NEG of 0 is 0, with the carry propagating through all bits.
  - NEG of 0x80000000 (WIDTH=32) is 0x80000000; no overflow flag.
- Opcode 7: out_result = 0, out_err = 1; still counted.
- Opcode 6 without the optional feature: same handling as opcode 7.
- out_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: BLU_ROTATE_EN.
- Defined:
  - Opcode 6 = rotate-right of in_a by in_b[$clog2(WIDTH)-1:0]. Amount 0 returns in_a unchanged.
  - Computed entirely in stage 1 and carried through stage 2 unchanged; latency is the same.
  - out_err = 0.
- Undefined: opcode 6 yields result 0 with out_err = 1, and no rotate logic is synthesised.

Decomposition:
- Package blu_pkg:
  - opcode localparams OP_NOT..OP_RSVD (3-bit).
  - stage-1 payload struct (op, low result, carry, a_hi, b_hi).
- One natural sub-module: blu_stage_reg, a valid/ready pipeline register parametrised on payload width, instantiated twice.
- Bitwise and NEG logic stays inline.

Test Plan:
- NEG, WIDTH=32, out_ready=1: a=0x00000001 → 0xFFFFFFFF after 2 cycles. a=0x00000000 → 0x00000000. a=0x00010000 → 0xFFFF0000 (carry crosses SPLIT=16).
- Back-to-back ops, one per cycle, out_ready=1:
  - AND 0xF0F0F0F0/0xFF00FF00 → 0xF000F000.
  - XOR → 0x0FF00FF0.
  - ANDN → 0x0F000F00.
  - NOT 0x12345678 → 0xEDCBA987.
  - Results on 4 consecutive cycles; out_count = 4.
- Backpressure: out_ready=0 for 5 cycles with 3 ops offered → exactly 2 accepted, in_ready=0, out_result stable. Release → remaining op drains in order, no loss or duplication.
- Opcode 7 (and opcode 6 without BLU_ROTATE_EN) → out_result=0, out_err=1, out_count increments.
- With BLU_ROTATE_EN: ROTR a=0x00000001, amount 1 → 0x80000000. Amount 0 → 0x00000001. out_err=0.
- Assert reset asynchronously with 2 ops in flight → out_valid=0 immediately and out_count=0. After release, no stale result appears. CNT_W=4: 16 handshakes → out_count wraps to 0.
